// File: rtl/cs_decoder_l11p1_k3_s2.sv
// Erasure decoder for the 3+2 cyclic-shift XOR code: collects five lifted symbols, solves, emits three info symbols.
// Optional macro CSDEC_PARITY_ERASE_EN promotes symbols with a bad lift parity bit to erased before solving.
module cs_decoder_l11p1_k3_s2 #(
    parameter int LIN  = 11,
    parameter int LOUT = 12
) (
    input  logic            aclk,
    input  logic            areset,
    input  logic [LOUT-1:0] s_axis_tdata,
    input  logic            s_axis_tuser,
    input  logic            s_axis_tvalid,
    output logic            s_axis_tready,
    input  logic            s_axis_tlast,
    output logic [LIN-1:0]  m_axis_tdata,
    output logic [1:0]      m_axis_tuser,
    output logic            m_axis_tvalid,
    input  logic            m_axis_tready,
    output logic            m_axis_tlast,
    output logic            frame_err,
    output logic [15:0]     fail_cnt
);

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        SOLVE   = 2'd1,
        EMIT    = 2'd2
    } state_t;

    function automatic logic [LOUT-1:0] rotl(input logic [LOUT-1:0] v, input int s);
        return (v << s) | (v >> (LOUT - s));
    endfunction

    function automatic logic [LOUT-1:0] rotr(input logic [LOUT-1:0] v, input int s);
        return rotl(v, LOUT - s);
    endfunction

    function automatic logic [LOUT-1:0] enc_p0(input logic [LOUT-1:0] a, input logic [LOUT-1:0] b,
                                               input logic [LOUT-1:0] c);
        return a ^ rotl(b, 1) ^ rotl(c, 2);
    endfunction

    function automatic logic [LOUT-1:0] enc_p1(input logic [LOUT-1:0] a, input logic [LOUT-1:0] b,
                                               input logic [LOUT-1:0] c);
        return a ^ rotl(b, 5) ^ rotl(c, 10);
    endfunction

    state_t          state_q, state_d;
    logic [2:0]      idx_q, idx_d;
    logic [4:0]      er_q, er_d;
    logic [LOUT-1:0] sym_q [5];
    logic [LOUT-1:0] sym_d [5];
    logic [LIN-1:0]  out_q [3];
    logic [LIN-1:0]  out_d [3];
    logic [1:0]      osel_q, osel_d;
    logic [LIN-1:0]  tdata_q, tdata_d;
    logic [1:0]      tuser_q, tuser_d;
    logic            tvalid_q, tvalid_d;
    logic            tlast_q, tlast_d;
    logic            frame_err_q, frame_err_d;
    logic [15:0]     fail_cnt_q, fail_cnt_d;

    // Solver: combinational over the collected frame, consumed only in SOLVE
    logic [LOUT-1:0] c0, c1, c2, p0, p1, r0, r1, r2;
    logic [4:0]      ers;
    logic [1:0]      n_info;
    logic            use_p0, sol_fail, sol_corr;

    always_comb begin
        c0 = sym_q[0];
        c1 = sym_q[1];
        c2 = sym_q[2];
        p0 = sym_q[3];
        p1 = sym_q[4];
        ers = er_q;
`ifdef CSDEC_PARITY_ERASE_EN
        for (int i = 0; i < 5; i++) begin
            if (!er_q[i] && (^sym_q[i])) ers[i] = 1'b1;
        end
`endif
        n_info   = 2'(ers[0]) + 2'(ers[1]) + 2'(ers[2]);
        use_p0   = !ers[3];
        r0       = c0;
        r1       = c1;
        r2       = c2;
        sol_fail = 1'b0;
        sol_corr = 1'b0;
        if (n_info == 2'd0) begin
            if (!ers[3] && (p0 != enc_p0(c0, c1, c2))) sol_fail = 1'b1;
            if (!ers[4] && (p1 != enc_p1(c0, c1, c2))) sol_fail = 1'b1;
        end else if ((n_info == 2'd1) && !(ers[3] && ers[4])) begin
            sol_corr = 1'b1;
            if (ers[0]) begin
                r0 = use_p0 ? (p0 ^ rotl(c1, 1) ^ rotl(c2, 2))
                            : (p1 ^ rotl(c1, 5) ^ rotl(c2, 10));
            end else if (ers[1]) begin
                r1 = use_p0 ? rotr(p0 ^ c0 ^ rotl(c2, 2), 1)
                            : rotr(p1 ^ c0 ^ rotl(c2, 10), 5);
            end else begin
                r2 = use_p0 ? rotr(p0 ^ c0 ^ rotl(c1, 1), 2)
                            : rotr(p1 ^ c0 ^ rotl(c1, 5), 10);
            end
            // With both parities present, p1 cross-checks the p0-based recovery
            if (!ers[3] && !ers[4] && (p1 != enc_p1(r0, r1, r2))) sol_fail = 1'b1;
        end else begin
            sol_fail = 1'b1;
            if (ers[0]) r0 = '0;
            if (ers[1]) r1 = '0;
            if (ers[2]) r2 = '0;
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        er_d        = er_q;
        osel_d      = osel_q;
        tdata_d     = tdata_q;
        tuser_d     = tuser_q;
        tvalid_d    = tvalid_q;
        tlast_d     = tlast_q;
        frame_err_d = frame_err_q;
        fail_cnt_d  = fail_cnt_q;
        for (int i = 0; i < 5; i++) sym_d[i] = sym_q[i];
        for (int i = 0; i < 3; i++) out_d[i] = out_q[i];

        case (state_q)
            COLLECT: begin
                if (s_axis_tvalid && s_axis_tready) begin
                    sym_d[idx_q] = s_axis_tdata;
                    er_d[idx_q]  = s_axis_tuser;
                    idx_d        = idx_q + 3'd1;
                    if (s_axis_tlast || (idx_q == 3'd4)) begin
                        state_d = SOLVE;
                        idx_d   = 3'd0;
                        if (!s_axis_tlast) frame_err_d = 1'b1;
                        if (s_axis_tlast && (idx_q != 3'd4)) begin
                            frame_err_d = 1'b1;
                            for (int j = 0; j < 5; j++) begin
                                if (j > int'(idx_q)) er_d[j] = 1'b1;
                            end
                        end
                    end
                end
            end
            SOLVE: begin
                state_d  = EMIT;
                out_d[0] = r0[LIN-1:0];
                out_d[1] = r1[LIN-1:0];
                out_d[2] = r2[LIN-1:0];
                tdata_d  = r0[LIN-1:0];
                tuser_d  = {sol_fail, sol_corr};
                tvalid_d = 1'b1;
                tlast_d  = 1'b0;
                osel_d   = 2'd0;
                if (sol_fail && (fail_cnt_q != 16'hFFFF)) fail_cnt_d = fail_cnt_q + 16'd1;
            end
            EMIT: begin
                if (m_axis_tready) begin
                    if (osel_q == 2'd2) begin
                        state_d  = COLLECT;
                        tvalid_d = 1'b0;
                        tlast_d  = 1'b0;
                        osel_d   = 2'd0;
                    end else begin
                        osel_d  = osel_q + 2'd1;
                        tdata_d = (osel_q == 2'd0) ? out_q[1] : out_q[2];
                        tlast_d = (osel_q == 2'd1);
                    end
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q     <= COLLECT;
            idx_q       <= 3'd0;
            er_q        <= 5'd0;
            osel_q      <= 2'd0;
            tdata_q     <= '0;
            tuser_q     <= 2'd0;
            tvalid_q    <= 1'b0;
            tlast_q     <= 1'b0;
            frame_err_q <= 1'b0;
            fail_cnt_q  <= 16'd0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            er_q        <= er_d;
            osel_q      <= osel_d;
            tdata_q     <= tdata_d;
            tuser_q     <= tuser_d;
            tvalid_q    <= tvalid_d;
            tlast_q     <= tlast_d;
            frame_err_q <= frame_err_d;
            fail_cnt_q  <= fail_cnt_d;
        end
    end

    // Symbol and result storage carries no reset; every frame rewrites or erases all slots
    always_ff @(posedge aclk) begin
        for (int i = 0; i < 5; i++) sym_q[i] <= sym_d[i];
        for (int i = 0; i < 3; i++) out_q[i] <= out_d[i];
    end

    assign s_axis_tready = (state_q == COLLECT) && !areset;
    assign m_axis_tdata  = tdata_q;
    assign m_axis_tuser  = tuser_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tlast_q;
    assign frame_err     = frame_err_q;
    assign fail_cnt      = fail_cnt_q;

endmodule

// File: tb/tb_cs_decoder_l11p1_k3_s2.sv
// Bench for cs_decoder_l11p1_k3_s2: directed frames plus randomized frames against an algebraic reference model.
module tb_cs_decoder_l11p1_k3_s2;

    logic        aclk = 1'b0;
    logic        areset;
    logic [11:0] s_axis_tdata;
    logic        s_axis_tuser;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic        s_axis_tlast;
    logic [10:0] m_axis_tdata;
    logic [1:0]  m_axis_tuser;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        m_axis_tlast;
    logic        frame_err;
    logic [15:0] fail_cnt;

    always #5 aclk = ~aclk;

    cs_decoder_l11p1_k3_s2 dut (
        .aclk          (aclk),
        .areset        (areset),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tuser  (s_axis_tuser),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .frame_err     (frame_err),
        .fail_cnt      (fail_cnt)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Current frame: five slot values, erasure flags, beats actually sent, tlast on the final beat
    logic [11:0] fd [5];
    logic        fu [5];
    int          nb;
    logic        lst;
    logic [10:0] exp_o [3];
    logic [1:0]  exp_u;
    logic        exp_ferr = 1'b0;
    logic [15:0] exp_fcnt = 16'd0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] rl(input logic [11:0] v, input int s);
        logic [23:0] t;
        t = {v, v} << s;
        return t[23:12];
    endfunction

    function automatic logic [11:0] lift(input logic [10:0] x);
        return {^x, x};
    endfunction

    function automatic logic [11:0] e0(input logic [11:0] a, input logic [11:0] b, input logic [11:0] c);
        return a ^ rl(b, 1) ^ rl(c, 2);
    endfunction

    function automatic logic [11:0] e1(input logic [11:0] a, input logic [11:0] b, input logic [11:0] c);
        return a ^ rl(b, 5) ^ rl(c, 10);
    endfunction

    // Reference: erased info symbol found by exhaustive search over the parity equation
    task automatic model();
        logic        er [5];
        logic [11:0] c [3];
        int          ne;
        int          m;
        logic        f;
        logic        k;
        for (int i = 0; i < 5; i++) er[i] = fu[i] || (i >= nb);
`ifdef CSDEC_PARITY_ERASE_EN
        for (int i = 0; i < 5; i++) if (!er[i] && (^fd[i])) er[i] = 1'b1;
`endif
        ne = 0;
        m  = 0;
        for (int i = 0; i < 3; i++) begin
            c[i] = fd[i];
            if (er[i]) begin
                ne++;
                m = i;
            end
        end
        f = 1'b0;
        k = 1'b0;
        if (ne == 0) begin
            f = (!er[3] && (e0(c[0], c[1], c[2]) != fd[3])) ||
                (!er[4] && (e1(c[0], c[1], c[2]) != fd[4]));
        end else if (ne == 1 && (!er[3] || !er[4])) begin
            k = 1'b1;
            for (int v = 0; v < 4096; v++) begin
                c[m] = 12'(v);
                if (!er[3] ? (e0(c[0], c[1], c[2]) == fd[3]) : (e1(c[0], c[1], c[2]) == fd[4])) break;
            end
            f = !er[3] && !er[4] && (e1(c[0], c[1], c[2]) != fd[4]);
        end else begin
            f = 1'b1;
            for (int i = 0; i < 3; i++) if (er[i]) c[i] = 12'd0;
        end
        for (int i = 0; i < 3; i++) exp_o[i] = c[i][10:0];
        exp_u = {f, k};
        if (f && exp_fcnt != 16'hFFFF) exp_fcnt++;
        if (nb < 5 || !lst) exp_ferr = 1'b1;
    endtask

    task automatic set_clean(input logic [10:0] a, input logic [10:0] b, input logic [10:0] c);
        fd[0] = lift(a);
        fd[1] = lift(b);
        fd[2] = lift(c);
        fd[3] = e0(fd[0], fd[1], fd[2]);
        fd[4] = e1(fd[0], fd[1], fd[2]);
        for (int i = 0; i < 5; i++) fu[i] = 1'b0;
        nb  = 5;
        lst = 1'b1;
    endtask

    // Called and returns at a negedge; the beat is accepted on the posedge in between
    task automatic send_beat(input logic [11:0] d, input logic u, input logic l);
        int n;
        n = 0;
        s_axis_tdata  = d;
        s_axis_tuser  = u;
        s_axis_tlast  = l;
        s_axis_tvalid = 1'b1;
        while (!s_axis_tready && n < 20) begin
            @(negedge aclk);
            n++;
        end
        if (n >= 20) chk("in_ready_timeout", 32'(s_axis_tready), 32'd1);
        @(negedge aclk);
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    // bp: 0 always ready, 1 random ready, 2 repeating 1-0-0-1 pattern
    task automatic receive(input int bp);
        int   cyc;
        int   n;
        logic done;
        logic r;
        cyc = 0;
        for (int k = 0; k < 3; k++) begin
            n    = 0;
            done = 1'b0;
            while (!done) begin
                case (bp)
                    0:       r = 1'b1;
                    1:       r = 1'($urandom_range(0, 1));
                    default: r = ((cyc % 4) == 0) || ((cyc % 4) == 3);
                endcase
                if (n >= 6) r = 1'b1;
                m_axis_tready = r;
                chk("out_vld", 32'(m_axis_tvalid), 32'd1);
                chk("out_data", 32'(m_axis_tdata), 32'(exp_o[k]));
                chk("out_user", 32'(m_axis_tuser), 32'(exp_u));
                chk("out_last", 32'(m_axis_tlast), 32'(k == 2));
                if (r) done = 1'b1;
                @(negedge aclk);
                cyc++;
                n++;
            end
        end
        m_axis_tready = 1'b0;
    endtask

    task automatic run_frame(input int bp);
        model();
        for (int i = 0; i < nb; i++) send_beat(fd[i], fu[i], (i == nb - 1) ? lst : 1'b0);
        chk("solve_vld", 32'(m_axis_tvalid), 32'd0);
        @(negedge aclk);
        chk("lat_vld", 32'(m_axis_tvalid), 32'd1);
        receive(bp);
        chk("idle_vld", 32'(m_axis_tvalid), 32'd0);
        chk("idle_rdy", 32'(s_axis_tready), 32'd1);
        chk("frame_err", 32'(frame_err), 32'(exp_ferr));
        chk("fail_cnt", 32'(fail_cnt), 32'(exp_fcnt));
    endtask

    initial begin
        int r;
        int s;
        areset        = 1'b1;
        s_axis_tdata  = 12'd0;
        s_axis_tuser  = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        m_axis_tready = 1'b0;
        repeat (3) @(negedge aclk);
        chk("rst_vld", 32'(m_axis_tvalid), 32'd0);
        chk("rst_last", 32'(m_axis_tlast), 32'd0);
        chk("rst_data", 32'(m_axis_tdata), 32'd0);
        chk("rst_user", 32'(m_axis_tuser), 32'd0);
        chk("rst_ferr", 32'(frame_err), 32'd0);
        chk("rst_fcnt", 32'(fail_cnt), 32'd0);
        chk("rst_rdy", 32'(s_axis_tready), 32'd0);
        areset = 1'b0;
        @(negedge aclk);
        chk("post_rst_rdy", 32'(s_axis_tready), 32'd1);

        set_clean(11'h001, 11'h002, 11'h004);
        run_frame(0);
        set_clean(11'h001, 11'h002, 11'h004);
        fu[1] = 1'b1;
        fd[1] = 12'h000;
        run_frame(0);
        set_clean(11'h001, 11'h002, 11'h004);
        fu[0] = 1'b1;
        fu[3] = 1'b1;
        run_frame(0);
        set_clean(11'h001, 11'h002, 11'h004);
        fu[0] = 1'b1;
        fu[1] = 1'b1;
        run_frame(0);
        set_clean(11'h001, 11'h002, 11'h004);
        fd[4] = 12'hA53;
        run_frame(0);
        set_clean(11'h001, 11'h002, 11'h004);
        run_frame(2);
        set_clean(11'h001, 11'h002, 11'h004);
        fd[2] = 12'h004;
        run_frame(0);
        set_clean(11'h001, 11'h002, 11'h004);
        nb = 3;
        run_frame(0);

        // Reset while the first output is waiting under backpressure
        set_clean(11'h001, 11'h002, 11'h004);
        for (int i = 0; i < 5; i++) send_beat(fd[i], fu[i], i == 4);
        @(negedge aclk);
        chk("pre_rst_vld", 32'(m_axis_tvalid), 32'd1);
        m_axis_tready = 1'b0;
        areset        = 1'b1;
        @(negedge aclk);
        chk("emit_rst_vld", 32'(m_axis_tvalid), 32'd0);
        chk("emit_rst_rdy", 32'(s_axis_tready), 32'd0);
        chk("emit_rst_ferr", 32'(frame_err), 32'd0);
        chk("emit_rst_fcnt", 32'(fail_cnt), 32'd0);
        areset   = 1'b0;
        exp_ferr = 1'b0;
        exp_fcnt = 16'd0;
        @(negedge aclk);
        set_clean(11'h001, 11'h002, 11'h004);
        run_frame(0);
        set_clean(11'h3A5, 11'h0F0, 11'h7FF);
        lst = 1'b0;
        run_frame(1);

        for (int f = 0; f < 150; f++) begin
            set_clean(11'($urandom), 11'($urandom), 11'($urandom));
            if ($urandom_range(0, 5) == 0) begin
                s = $urandom_range(0, 4);
                fd[s] = fd[s] ^ (12'd1 << $urandom_range(0, 11));
            end
            for (int i = 0; i < 5; i++) begin
                if ($urandom_range(0, 4) == 0) begin
                    fu[i] = 1'b1;
                    fd[i] = 12'($urandom);
                end
            end
            r = $urandom_range(0, 9);
            if (r == 0) nb = $urandom_range(3, 4);
            else if (r == 1) lst = 1'b0;
            run_frame($urandom_range(0, 2));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
